// File: rtl/pc_fetch.sv
// Instruction fetch front end: holds the PC, applies branch-unit redirects,
// issues one outstanding imem request at a time and buffers the word for decode.
module pc_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  pcsrcs,
    input  logic [31:0] ex_pc4,
    input  logic [25:0] ex_jindex,
    input  logic [15:0] ex_imm,
    input  logic [31:0] jr_target,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        inst_valid,
    input  logic        dec_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic [31:0] inst_pc4,
    output logic        misalign_err
);

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] WORD_BYTES = XLEN'(4);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] req_pc_q, req_pc_d;
    logic            discard_q, discard_d;
    logic [XLEN-1:0] inst_q, inst_d;
    logic [XLEN-1:0] inst_pc_q, inst_pc_d;
    logic [XLEN-1:0] inst_pc4_q, inst_pc4_d;
    logic            inst_valid_q, inst_valid_d;
    logic            misalign_q, misalign_d;

    logic            redirect_c;
    logic [XLEN-1:0] target_raw_c;
    logic [XLEN-1:0] target_c;

    // Redirect target selection; low bits are always forced to a word boundary
    always_comb begin
        redirect_c   = (pcsrcs != 2'b11);
        target_raw_c = pc_q;
        case (pcsrcs)
            2'b00:   target_raw_c = jr_target;
            2'b01:   target_raw_c = {ex_pc4[31:28], ex_jindex, 2'b00};
            2'b10:   target_raw_c = ex_pc4 + {{14{ex_imm[15]}}, ex_imm, 2'b00};
            default: target_raw_c = pc_q;
        endcase
        target_c = {target_raw_c[XLEN-1:2], 2'b00};
    end

    // State and datapath registers; synchronous reset is folded into the _d logic
    always_ff @(posedge clk) begin
        state_q      <= state_d;
        pc_q         <= pc_d;
        req_pc_q     <= req_pc_d;
        discard_q    <= discard_d;
        inst_q       <= inst_d;
        inst_pc_q    <= inst_pc_d;
        inst_pc4_q   <= inst_pc4_d;
        inst_valid_q <= inst_valid_d;
        misalign_q   <= misalign_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH: if (imem_req_ready) state_d = S_WAIT;
            S_WAIT: begin
                if (imem_resp_valid) begin
                    state_d = (discard_q || redirect_c) ? S_FETCH : S_HOLD;
                end
            end
            S_HOLD:  if (redirect_c || dec_ready) state_d = S_FETCH;
            default: state_d = S_FETCH;
        endcase
        if (reset) state_d = S_FETCH;
    end

    // Datapath next values and request outputs
    always_comb begin
        pc_d         = pc_q;
        req_pc_d     = req_pc_q;
        discard_d    = discard_q;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        inst_pc4_d   = inst_pc4_q;
        inst_valid_d = inst_valid_q;
        misalign_d   = 1'b0;

        case (state_q)
            S_FETCH: begin
                // A response seen here can only be the stale one left over from a reset
                if (imem_resp_valid) discard_d = 1'b0;
                if (imem_req_ready) begin
                    req_pc_d = pc_q;
                    pc_d     = pc_q + WORD_BYTES;
                    if (redirect_c) discard_d = 1'b1;
                end
            end
            S_WAIT: begin
                if (imem_resp_valid) begin
                    if (!discard_q && !redirect_c) begin
                        inst_d       = imem_resp_data;
                        inst_pc_d    = req_pc_q;
                        inst_pc4_d   = req_pc_q + WORD_BYTES;
                        inst_valid_d = 1'b1;
                    end
                    discard_d = 1'b0;
                end else if (redirect_c) begin
                    discard_d = 1'b1;
                end
            end
            S_HOLD: begin
                if (redirect_c || dec_ready) inst_valid_d = 1'b0;
            end
            default: inst_valid_d = 1'b0;
        endcase

        if (redirect_c) begin
            pc_d       = target_c;
            misalign_d = (pcsrcs == 2'b00) && (jr_target[1:0] != 2'b00);
        end

        if (reset) begin
            pc_d         = RESET_PC;
            req_pc_d     = '0;
            discard_d    = (state_q == S_WAIT);
            inst_d       = '0;
            inst_pc_d    = '0;
            inst_pc4_d   = '0;
            inst_valid_d = 1'b0;
            misalign_d   = 1'b0;
        end
    end

    // Output decode
    always_comb begin
        imem_req_valid = (state_q == S_FETCH) && !reset;
        imem_addr      = pc_q;
        inst_valid     = inst_valid_q;
        inst           = inst_q;
        inst_pc        = inst_pc_q;
        inst_pc4       = inst_pc4_q;
        misalign_err   = misalign_q;
    end

endmodule

// File: tb/tb_pc_fetch.sv
// Bench for pc_fetch: directed scenarios plus random fetch/redirect traffic
// checked against an address/target model derived from the redirect rules.
module tb_pc_fetch;

    localparam logic [31:0] RPC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  pcsrcs;
    logic [31:0] ex_pc4;
    logic [25:0] ex_jindex;
    logic [15:0] ex_imm;
    logic [31:0] jr_target;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        inst_valid;
    logic        dec_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [31:0] inst_pc4;
    logic        misalign_err;

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] m_pc;
    logic [31:0] m_req;

    always #5 clk = ~clk;

    pc_fetch #(.RESET_PC(RPC)) dut (
        .clk(clk), .reset(reset), .pcsrcs(pcsrcs), .ex_pc4(ex_pc4),
        .ex_jindex(ex_jindex), .ex_imm(ex_imm), .jr_target(jr_target),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_addr(imem_addr), .imem_resp_valid(imem_resp_valid),
        .imem_resp_data(imem_resp_data), .inst_valid(inst_valid),
        .dec_ready(dec_ready), .inst(inst), .inst_pc(inst_pc),
        .inst_pc4(inst_pc4), .misalign_err(misalign_err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Redirect target straight from the architectural definition
    function automatic logic [31:0] ref_target(input logic [1:0] sel, input logic [31:0] pc4,
                                               input logic [25:0] ji, input logic [15:0] imm,
                                               input logic [31:0] jr);
        int off;
        off = int'($signed(imm)) * 4;
        case (sel)
            2'd0:    return jr & 32'hFFFF_FFFC;
            2'd1:    return (pc4 & 32'hF000_0000) | (32'(ji) * 32'd4);
            2'd2:    return (pc4 + 32'(off)) & 32'hFFFF_FFFC;
            default: return 32'h0;
        endcase
    endfunction

    task automatic wait_req();
        int t = 0;
        while (!imem_req_valid && t < 50) begin
            step();
            t++;
        end
        chk("req_valid_timeout", 32'(imem_req_valid), 32'd1);
    endtask

    task automatic issue();
        wait_req();
        chk("imem_addr", imem_addr, m_pc);
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        chk("req_low_in_wait", 32'(imem_req_valid), 32'd0);
        m_req = m_pc;
        m_pc  = m_pc + 32'd4;
    endtask

    task automatic respond(input int k, input logic [31:0] d);
        repeat (k - 1) begin
            step();
            chk("no_inst_before_resp", 32'(inst_valid), 32'd0);
        end
        imem_resp_valid = 1'b1;
        imem_resp_data  = d;
        step();
        imem_resp_valid = 1'b0;
        imem_resp_data  = $urandom;
    endtask

    task automatic check_held(input logic [31:0] d);
        chk("inst_valid", 32'(inst_valid), 32'd1);
        chk("inst", inst, d);
        chk("inst_pc", inst_pc, m_req);
        chk("inst_pc4", inst_pc4, m_req + 32'd4);
    endtask

    task automatic retire(input int hold, input logic [31:0] d);
        dec_ready = 1'b0;
        repeat (hold) begin
            step();
            chk("bp_inst_stable", inst, d);
            chk("bp_pc_stable", inst_pc, m_req);
            chk("bp_valid", 32'(inst_valid), 32'd1);
            chk("bp_no_req", 32'(imem_req_valid), 32'd0);
        end
        dec_ready = 1'b1;
        step();
        dec_ready = 1'b0;
        chk("retired", 32'(inst_valid), 32'd0);
        chk("req_after_handshake", 32'(imem_req_valid), 32'd1);
    endtask

    task automatic fetch(input int k, input int hold);
        logic [31:0] d;
        d = $urandom;
        issue();
        respond(k, d);
        check_held(d);
        retire(hold, d);
    endtask

    task automatic set_redirect(input logic [1:0] sel, input logic [31:0] pc4, input logic [25:0] ji,
                                input logic [15:0] imm, input logic [31:0] jr);
        pcsrcs    = sel;
        ex_pc4    = pc4;
        ex_jindex = ji;
        ex_imm    = imm;
        jr_target = jr;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0]  sel;
        logic [31:0] rp4, rjr;
        logic [25:0] rji;
        logic [15:0] rim;
        logic [31:0] d;

        reset = 1'b1; pcsrcs = 2'b11; ex_pc4 = '0; ex_jindex = '0; ex_imm = '0;
        jr_target = '0; imem_req_ready = 1'b0; imem_resp_valid = 1'b0;
        imem_resp_data = '0; dec_ready = 1'b0;
        step();
        step();
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_inst_valid", 32'(inst_valid), 32'd0);
        chk("rst_inst", inst, 32'h0);
        chk("rst_inst_pc", inst_pc, 32'h0);
        chk("rst_inst_pc4", inst_pc4, 32'h0);
        chk("rst_misalign", 32'(misalign_err), 32'd0);
        reset = 1'b0;
        #1;
        m_pc = RPC;
        chk("post_rst_addr", imem_addr, 32'h0000_0100);

        // Sequential stream from RESET_PC, k=1
        repeat (3) fetch(1, 0);
        chk("seq_next_addr", imem_addr, 32'h0000_010C);

        // Branch taken while holding, dec_ready also high
        issue();
        d = $urandom;
        respond(1, d);
        check_held(d);
        set_redirect(2'b10, 32'h0000_0200, 26'h0, 16'hFFFC, 32'h0);
        dec_ready = 1'b1;
        step();
        pcsrcs = 2'b11; dec_ready = 1'b0;
        m_pc = ref_target(2'b10, 32'h0000_0200, 26'h0, 16'hFFFC, 32'h0);
        chk("br_hold_drop", 32'(inst_valid), 32'd0);
        chk("br_hold_req", 32'(imem_req_valid), 32'd1);
        chk("br_hold_addr", imem_addr, 32'h0000_01F0);

        // J while waiting: pending response is discarded
        issue();
        set_redirect(2'b01, 32'h4000_0010, 26'h0000040, 16'h0, 32'h0);
        step();
        pcsrcs = 2'b11;
        m_pc = ref_target(2'b01, 32'h4000_0010, 26'h0000040, 16'h0, 32'h0);
        chk("j_wait_no_req", 32'(imem_req_valid), 32'd0);
        respond(1, $urandom);
        chk("j_wait_dropped", 32'(inst_valid), 32'd0);
        chk("j_wait_addr", imem_addr, 32'h4000_0100);
        fetch(2, 1);

        // Misaligned JR in FETCH with memory not ready
        set_redirect(2'b00, 32'h0, 26'h0, 16'h0, 32'h0000_3003);
        step();
        pcsrcs = 2'b11;
        m_pc = 32'h0000_3000;
        chk("jr_misalign_hi", 32'(misalign_err), 32'd1);
        chk("jr_addr", imem_addr, 32'h0000_3000);
        step();
        chk("jr_misalign_lo", 32'(misalign_err), 32'd0);
        fetch(1, 0);

        // Wrap past the top of the address space
        set_redirect(2'b00, 32'h0, 26'h0, 16'h0, 32'hFFFF_FFFC);
        step();
        pcsrcs = 2'b11;
        chk("wrap_no_misalign", 32'(misalign_err), 32'd0);
        m_pc = 32'hFFFF_FFFC;
        fetch(1, 0);
        chk("wrap_addr", imem_addr, 32'h0000_0000);
        fetch(1, 5);

        // Redirect coinciding with request acceptance
        wait_req();
        chk("acc_redir_old_addr", imem_addr, m_pc);
        imem_req_ready = 1'b1;
        set_redirect(2'b10, 32'h0000_8000, 26'h0, 16'h0010, 32'h0);
        step();
        imem_req_ready = 1'b0; pcsrcs = 2'b11;
        m_pc = ref_target(2'b10, 32'h0000_8000, 26'h0, 16'h0010, 32'h0);
        chk("acc_redir_wait", 32'(imem_req_valid), 32'd0);
        respond(1, $urandom);
        chk("acc_redir_dropped", 32'(inst_valid), 32'd0);
        chk("acc_redir_addr", imem_addr, m_pc);

        // Redirect in WAIT with response in the same cycle
        issue();
        set_redirect(2'b01, 32'h2000_0000, 26'h0123456, 16'h0, 32'h0);
        imem_resp_valid = 1'b1;
        imem_resp_data  = $urandom;
        step();
        imem_resp_valid = 1'b0; pcsrcs = 2'b11;
        m_pc = ref_target(2'b01, 32'h2000_0000, 26'h0123456, 16'h0, 32'h0);
        chk("wait_resp_redir_drop", 32'(inst_valid), 32'd0);
        chk("wait_resp_redir_req", 32'(imem_req_valid), 32'd1);
        chk("wait_resp_redir_addr", imem_addr, m_pc);
        fetch(1, 0);

        // Reset during WAIT, stale response afterwards
        issue();
        reset = 1'b1;
        #1;
        chk("rst_cycle_req_low", 32'(imem_req_valid), 32'd0);
        step();
        reset = 1'b0;
        #1;
        m_pc = RPC;
        chk("rst_wait_addr", imem_addr, RPC);
        chk("rst_wait_inst_valid", 32'(inst_valid), 32'd0);
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'hDEAD_BEEF;
        step();
        imem_resp_valid = 1'b0;
        chk("stale_ignored", 32'(inst_valid), 32'd0);
        fetch(1, 0);
        fetch(3, 2);

        // Random traffic
        for (int it = 0; it < 40; it++) begin
            sel = 2'($urandom_range(0, 2));
            rp4 = $urandom; rji = 26'($urandom); rim = 16'($urandom); rjr = $urandom;
            case ($urandom_range(0, 3))
                0, 1: fetch(int'($urandom_range(1, 3)), int'($urandom_range(0, 3)));
                2: begin
                    issue();
                    d = $urandom;
                    respond(int'($urandom_range(1, 3)), d);
                    check_held(d);
                    set_redirect(sel, rp4, rji, rim, rjr);
                    dec_ready = 1'($urandom_range(0, 1));
                    step();
                    pcsrcs = 2'b11; dec_ready = 1'b0;
                    m_pc = ref_target(sel, rp4, rji, rim, rjr);
                    chk("rnd_hold_drop", 32'(inst_valid), 32'd0);
                    chk("rnd_misalign", 32'(misalign_err),
                        32'((sel == 2'd0) && (rjr[1:0] != 2'b00)));
                    chk("rnd_hold_addr", imem_addr, m_pc);
                end
                default: begin
                    wait_req();
                    set_redirect(sel, rp4, rji, rim, rjr);
                    step();
                    pcsrcs = 2'b11;
                    m_pc = ref_target(sel, rp4, rji, rim, rjr);
                    chk("rnd_fetch_req", 32'(imem_req_valid), 32'd1);
                    chk("rnd_fetch_addr", imem_addr, m_pc);
                end
            endcase
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_fetch.md
Name: pc_fetch

Overview:
- Instruction fetch front end. Consumes the 2-bit PC-source select produced by the branch unit, holds the program counter, issues one-at-a-time requests to instruction memory and presents fetched instructions to decode.
- Sits between the branch unit (upstream, redirect source), instruction memory (valid/ready request, valid response) and decode (valid/ready).

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.

Ports:
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  reset, synchronous, active-high
- pcsrcs  input  2  PC source select: 00 JR, 01 J/JAL, 10 branch taken, 11 sequential (no redirect)
- ex_pc4  input  32  PC+4 of the redirecting instruction
- ex_jindex  input  26  J/JAL instruction index field
- ex_imm  input  16  branch offset in words, signed
- jr_target  input  32  register value for JR
- imem_req_valid  output  1  fetch request valid
- imem_req_ready  input  1  memory accepts request
- imem_addr  output  32  fetch byte address
- imem_resp_valid  input  1  read data valid, one cycle pulse
- imem_resp_data  input  32  instruction word
- inst_valid  output  1  instruction available to decode
- dec_ready  input  1  decode accepts instruction
- inst  output  32  held instruction word
- inst_pc  output  32  address of held instruction
- inst_pc4  output  32  inst_pc + 4
- misalign_err  output  1  one-cycle pulse: redirect target had nonzero bits [1:0]

Behaviour:
- Reset, synchronous: pc=RESET_PC, state=FETCH, discard=0, imem_req_valid=0 during the reset cycle, inst_valid=0, inst=0, inst_pc=0, inst_pc4=0, misalign_err=0. Reset overrides everything, including an outstanding request. A response arriving after reset for a request made before reset must be ignored; discard=1 is set if reset occurs in WAIT.
- Redirect targets:
  - 00: jr_target.
  - 01: {ex_pc4[31:28], ex_jindex, 2'b00}.
  - 10: ex_pc4 + (sign_extend(ex_imm) << 2), mod 2^32.
  - 11: no redirect.
  - Targets are forced to bits[1:0]=00. misalign_err pulses the next cycle if jr_target[1:0]!=0 on a JR redirect.
- States:
  - FETCH: imem_req_valid=1, imem_addr=pc. When imem_req_ready=1: req_pc<=pc, pc<=pc+4 (wraps FFFF_FFFC -> 0000_0000), go to WAIT.
  - WAIT: imem_req_valid=0. On imem_resp_valid=1:
    - discard=1: drop the data, clear discard, go to FETCH.
    - Otherwise: inst<=imem_resp_data, inst_pc<=req_pc, inst_pc4<=req_pc+4, inst_valid<=1, go to HOLD.
  - HOLD: inst_valid=1, outputs stable. When dec_ready=1: inst_valid<=0, go to FETCH. The next request is issued the cycle after the handshake.
- Latency: request accepted in cycle N, response in N+k, inst_valid=1 from N+k+1. Minimum issue-to-issue is 3 cycles with k=1 and dec_ready held high.
- Redirect (pcsrcs!=11) has top priority in every state; it is sampled each cycle.
  - pc<=target.
  - FETCH with imem_req_ready=0: the request is withdrawn. Stay in FETCH; the new address is presented next cycle.
  - FETCH with imem_req_ready=1 in the same cycle: the old request is accepted. Set discard=1, go to WAIT; pc still becomes target, not pc+4.
  - WAIT: set discard=1 and stay in WAIT. If imem_resp_valid arrives in the same cycle, drop it, keep discard=0, go to FETCH.
  - HOLD: drop the held instruction (inst_valid<=0), go to FETCH, even if dec_ready=1 in the same cycle.
  - Back-to-back redirects: the last one wins. discard is a single bit; at most one outstanding request exists.
- imem_resp_valid in FETCH or HOLD is ignored.

Test Plan:
- Reset with RESET_PC=0x0000_0100, memory ready, k=1, dec_ready=1 -> addresses 0x100, 0x104, 0x108 in order; inst_pc matches each; inst_pc4=inst_pc+4.
- Branch in HOLD: ex_pc4=0x0000_0200, ex_imm=16'hFFFC -> held instruction dropped, next imem_addr=0x0000_01F0.
- J redirect with pcsrcs=01, ex_pc4=0x4000_0010, ex_jindex=26'h0000040, issued in WAIT -> pending response dropped (inst_valid stays 0), next imem_addr=0x4000_0100.
- JR redirect with jr_target=0x0000_3003 -> imem_addr=0x0000_3000, misalign_err high exactly one cycle.
- pc=0xFFFF_FFFC sequential -> next imem_addr=0x0000_0000.
- Backpressure: dec_ready=0 for 5 cycles -> inst and inst_pc stable, no new imem request. Release -> one handshake, then a request the next cycle.
- Reset asserted in WAIT, then a stale response arrives -> stale response ignored; first inst delivered is from RESET_PC.
